// File: rtl/lfsr_scrambler_arbiter.sv
// Shares one PRBS7 (x^7+x^6+1) scrambler between two framed bit-serial requesters,
// arbitrating round-robin per frame and scrambling frame_len bits under valid/ready.
module lfsr_scrambler_arbiter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [6:0]       seed0,
    input  logic [6:0]       seed1,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             out_last,
    input  logic             out_ready,
    output logic             out_ch,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [6:0]       s;
    logic [LEN_W-1:0] remaining;
    logic             last_ch;
    logic             sel;
    logic [6:0]       seed_sel;
    logic             accept;
    logic             out_xfer;

    // With both channels requesting, the one not served last wins.
    always_comb begin
        sel = req[1];
        if (req == 2'b11) begin
            sel = ~last_ch;
        end
    end

    assign seed_sel = out_ch ? seed1 : seed0;
    assign in_ready = (state == RUN) && (remaining != '0) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s         <= 7'h7F;
            remaining <= '0;
            last_ch   <= 1'b1;
            out_ch    <= 1'b0;
            grant     <= 2'b00;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        out_ch <= sel;
                        grant  <= sel ? 2'b10 : 2'b01;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
                    s         <= (seed_sel == 7'h00) ? 7'h7F : seed_sel;
                    remaining <= frame_len;
                    state     <= (frame_len == '0) ? DONE : RUN;
                end
                RUN: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_bit   <= in_bit ^ s[6];
                        out_last  <= (remaining == LEN_W'(1));
                        remaining <= remaining - LEN_W'(1);
                        s         <= {s[5:0], s[6] ^ s[5]};
                    end else if (out_xfer) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    if (out_xfer && out_last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_ch <= out_ch;
                    grant   <= 2'b00;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_scrambler_arbiter.sv
// Table-driven bench for lfsr_scrambler_arbiter: per-frame vectors with hand-computed
// scrambled outputs, plus hand-written reset, timing and round-robin sequences.
module tb_lfsr_scrambler_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [6:0] seed0;
    logic [6:0] seed1;
    logic [7:0] frame_len;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    logic       out_ready;
    logic       out_ch;
    logic [1:0] grant;
    logic       busy;
    logic       done;

    lfsr_scrambler_arbiter #(.LEN_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .seed0(seed0),
        .seed1(seed1),
        .frame_len(frame_len),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_bit(out_bit),
        .out_last(out_last),
        .out_ready(out_ready),
        .out_ch(out_ch),
        .grant(grant),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [6:0] seed0;
        logic [6:0] seed1;
        int         len;
        logic [7:0] inBits;
        int         stallAt;
        logic [7:0] expBits;
        logic       expCh;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    logic       outQ[$];
    logic [1:0] grantQ[$];
    logic       chQ[$];
    int         frameBase;
    int         lastPos;
    int         doneSeen;
    int         busyCycles;
    int         lastCyc;
    int         doneCyc;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_grant"}, 32'(grant), 32'h0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'h0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        checkOutput({tag, "_out_bit"}, 32'(out_bit), 32'h0);
        checkOutput({tag, "_out_last"}, 32'(out_last), 32'h0);
        checkOutput({tag, "_out_ch"}, 32'(out_ch), 32'h0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h0);
    endtask

    // Drives requests and input bits, optionally stalls the output for 3 cycles once
    // stallAt bits have transferred, and logs transfers, grants and done pulses.
    task automatic applyStimulus(input logic [1:0] r, input logic [7:0] bits,
                                 input int stallAt, input int nFrames);
        int         idx = 0;
        int         stallLeft = (stallAt >= 0) ? 3 : 0;
        logic       held = 1'b0;
        bit         heldValid = 0;
        logic [1:0] prevGrant = grant;
        doneSeen   = 0;
        busyCycles = 0;
        lastPos    = -1;
        lastCyc    = -1;
        doneCyc    = -1;
        frameBase  = outQ.size();
        for (int cyc = 0; cyc < 400 && doneSeen < nFrames; cyc++) begin
            @(negedge clk);
            req       = r;
            in_valid  = 1'b1;
            in_bit    = (idx < 8) ? bits[idx] : 1'b0;
            out_ready = 1'b1;
            if (stallLeft > 0 && out_valid && (outQ.size() - frameBase) == stallAt) begin
                out_ready = 1'b0;
                stallLeft--;
            end
            #1;
            if (busy) busyCycles++;
            if (grant != 2'b00 && prevGrant == 2'b00) begin
                grantQ.push_back(grant);
                chQ.push_back(out_ch);
                idx       = 0;
                frameBase = outQ.size();
            end
            prevGrant = grant;
            if (!out_ready && out_valid) begin
                checkOutput("stall_in_ready", 32'(in_ready), 32'h0);
                if (heldValid) checkOutput("stall_hold_bit", 32'(out_bit), 32'(held));
                held      = out_bit;
                heldValid = 1;
            end
            if (done) begin
                doneSeen++;
                doneCyc = cyc;
            end
            if (out_valid && out_ready) begin
                outQ.push_back(out_bit);
                if (out_last) begin
                    lastPos = outQ.size() - 1 - frameBase;
                    lastCyc = cyc;
                end
            end
            if (in_valid && in_ready) idx++;
        end
        req      = 2'b00;
        in_valid = 1'b0;
        if (doneSeen < nFrames) checkOutput("timeout_done", 32'(doneSeen), 32'(nFrames));
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] got;
        int         n;
        int         rrBase;

        // Expected outputs packed with bit i = i-th scrambled bit of the frame.
        vecs[0] = '{req: 2'b01, seed0: 7'h55, seed1: 7'h00, len: 8, inBits: 8'h00, stallAt: -1, expBits: 8'hD5, expCh: 1'b0};
        vecs[1] = '{req: 2'b01, seed0: 7'h55, seed1: 7'h00, len: 8, inBits: 8'h00, stallAt: 3,  expBits: 8'hD5, expCh: 1'b0};
        vecs[2] = '{req: 2'b10, seed0: 7'h55, seed1: 7'h00, len: 7, inBits: 8'h00, stallAt: -1, expBits: 8'h7F, expCh: 1'b1};
        vecs[3] = '{req: 2'b01, seed0: 7'h55, seed1: 7'h00, len: 8, inBits: 8'hFF, stallAt: -1, expBits: 8'h2A, expCh: 1'b0};
        vecs[4] = '{req: 2'b10, seed0: 7'h00, seed1: 7'h55, len: 8, inBits: 8'hAA, stallAt: 2,  expBits: 8'h7F, expCh: 1'b1};
        vecs[5] = '{req: 2'b01, seed0: 7'h55, seed1: 7'h55, len: 0, inBits: 8'h00, stallAt: -1, expBits: 8'h00, expCh: 1'b0};

        reset     = 1'b1;
        req       = 2'b00;
        seed0     = 7'h55;
        seed1     = 7'h55;
        frame_len = 8'd8;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkReset("reset");

        // Request seen at edge T: LOAD after T, RUN with in_ready one cycle later.
        @(negedge clk);
        reset = 1'b0;
        req   = 2'b01;
        @(negedge clk);
        #1;
        checkOutput("load_grant", 32'(grant), 32'h1);
        checkOutput("load_busy", 32'(busy), 32'h1);
        checkOutput("load_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        #1;
        checkOutput("run_in_ready", 32'(in_ready), 32'h1);
        req   = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            seed0     = vecs[v].seed0;
            seed1     = vecs[v].seed1;
            frame_len = 8'(vecs[v].len);
            applyStimulus(vecs[v].req, vecs[v].inBits, vecs[v].stallAt, 1);
            n   = outQ.size() - frameBase;
            got = 8'h00;
            for (int i = 0; i < n && i < 8; i++) got[i] = outQ[frameBase + i];
            checkOutput($sformatf("v%0d_count", v), 32'(n), 32'(vecs[v].len));
            checkOutput($sformatf("v%0d_bits", v), 32'(got), 32'(vecs[v].expBits));
            checkOutput($sformatf("v%0d_last_pos", v), 32'(lastPos), 32'(vecs[v].len - 1));
            checkOutput($sformatf("v%0d_ch", v), 32'(chQ[chQ.size() - 1]), 32'(vecs[v].expCh));
            checkOutput($sformatf("v%0d_grant", v), 32'(grantQ[grantQ.size() - 1]),
                        vecs[v].expCh ? 32'h2 : 32'h1);
            checkOutput($sformatf("v%0d_done_count", v), 32'(doneSeen), 32'h1);
            if (vecs[v].len > 0)
                checkOutput($sformatf("v%0d_done_after_last", v), 32'(doneCyc), 32'(lastCyc + 1));
            if (vecs[v].stallAt < 0)
                checkOutput($sformatf("v%0d_busy_cycles", v), 32'(busyCycles),
                            (vecs[v].len == 0) ? 32'd2 : 32'(vecs[v].len + 3));
            @(negedge clk);
            #1;
            checkOutput($sformatf("v%0d_grant_released", v), 32'(grant), 32'h0);
            checkOutput($sformatf("v%0d_done_single", v), 32'(done), 32'h0);
        end

        // Reset during bit 3 of a channel 1 frame discards it without a done pulse.
        seed1     = 7'h55;
        frame_len = 8'd8;
        n         = 0;
        for (int cyc = 0; cyc < 50 && n < 2; cyc++) begin
            @(negedge clk);
            req      = 2'b10;
            in_valid = 1'b1;
            in_bit   = 1'b0;
            #1;
            if (in_valid && in_ready) n++;
        end
        checkOutput("pre_reset_accepts", 32'(n), 32'h2);
        @(negedge clk);
        reset = 1'b1;
        req   = 2'b00;
        @(negedge clk);
        #1;
        checkReset("midframe_reset");
        reset    = 1'b0;
        in_valid = 1'b0;
        n        = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (done) n++;
        end
        checkOutput("no_done_after_reset", 32'(n), 32'h0);

        // Both channels held: alternating grants starting with channel 0.
        seed0     = 7'h55;
        seed1     = 7'h55;
        frame_len = 8'd4;
        rrBase    = grantQ.size();
        n         = outQ.size();
        applyStimulus(2'b11, 8'h00, -1, 4);
        checkOutput("rr_done_count", 32'(doneSeen), 32'h4);
        checkOutput("rr_frames", 32'(grantQ.size() - rrBase), 32'h4);
        checkOutput("rr_bits", 32'(outQ.size() - n), 32'd16);
        for (int f = 0; f < 4 && rrBase + f < grantQ.size(); f++) begin
            checkOutput($sformatf("rr_grant%0d", f), 32'(grantQ[rrBase + f]),
                        (f % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput($sformatf("rr_ch%0d", f), 32'(chQ[rrBase + f]), 32'(f % 2));
        end
        got = 8'h00;
        for (int i = 0; i < 4 && (outQ.size() - 4 + i) >= 0; i++) got[i] = outQ[outQ.size() - 4 + i];
        checkOutput("rr_last_frame_bits", 32'(got), 32'h5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
